// File: rtl/enc4s_unit.sv
// enc4s_unit: multi-cycle AES/AES^-1/SM4 substitute-expand-accumulate unit; SM4 logic built only when ENC4S_SM4_EN is defined
module enc4s_unit #(
  parameter int LANES = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [2:0]       in_fn,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("enc4s_unit: LANES must be 1, 2 or 4");
  end
`ifdef ENC4S_SM4_EN
  localparam logic [2047:0] SM4_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] acc, rs2_q, mix;
  logic [2:0] fn_q;
  logic [TAG_W-1:0] tag_q;
  logic [1:0] k;
  logic accept, last;
  logic [31:0] contrib [LANES];
  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction
  function automatic logic [31:0] rl32(input logic [31:0] x, input logic [1:0] i);
    logic [63:0] t;
    t = {x, x} << {i, 3'b000};
    return t[63:32];
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = '0;
    p = a;
    for (int n = 0; n < 8; n++) begin
      r = b[n] ? r ^ p : r;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction
  // x^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int n = 0; n < 7; n++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [31:0] t_fn(input logic [7:0] x, input logic [2:0] fn);
    logic [7:0] v, s;
    logic [31:0] aes, sm4;
    v = ginv(fn[0] ? rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05 : x);
    s = fn[0] ? v : v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
    aes = fn[2] ? {24'h0, s} :
          fn[0] ? {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)} :
                  {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
`ifdef ENC4S_SM4_EN
    s = SM4_SBOX[{~x, 3'b000} +: 8];
    sm4 = fn[2] ? {s[2:0], 5'b0, s[0], 2'b0, s[7:3], 1'b0, s[7:1], s} :
                  {s[5:0], s, s[7:6], s[7:2], s[1:0] ^ s[7:6], s[7:2] ^ s[5:0], s[1:0]};
`else
    sm4 = '0;
`endif
    return fn[1] ? (fn[0] ? 32'h0 : sm4) : aes;
  endfunction
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [1:0] i;
    assign i = k + 2'(j);
    assign contrib[j] = rl32(t_fn(rs2_q[{i, 3'b000} +: 8], fn_q), i);
  end
  always_comb begin
    mix = '0;
    for (int n = 0; n < LANES; n++) mix ^= contrib[n];
  end
  assign last = k == 2'(4 - LANES);
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_rd = acc;
  assign out_tag = tag_q;
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    accept = in_valid && in_ready;
    state_nx = accept ? RUN :
               state == RUN ? (last ? DONE : RUN) :
               state == DONE && !out_ready ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      rs2_q <= '0;
      fn_q <= '0;
      tag_q <= '0;
      k <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc <= in_rs1;
        rs2_q <= in_rs2;
        fn_q <= in_fn;
        tag_q <= in_tag;
        k <= '0;
      end else if (state == RUN) begin
        acc <= acc ^ mix;
        k <= k + 2'(LANES);
      end
    end
endmodule
